// File: rtl/jk_pkg.sv
// Shared mode encoding for the JK register bank.
package jk_pkg;

  typedef enum logic [1:0] {
    MODE_JK   = 2'b00,
    MODE_UP   = 2'b01,
    MODE_DOWN = 2'b10,
    MODE_LOAD = 2'b11
  } jk_mode_t;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with enable, parallel load and async active-low reset
// to a per-instance value.
module jk_cell #(
  parameter logic RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic j,
  input  logic k,
  input  logic load,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= RESET_BIT;
    end else if (en) begin
      if (load) begin
        q <= d;
      end else begin
        case ({j, k})
          2'b01:   q <= 1'b0;
          2'b10:   q <= 1'b1;
          2'b11:   q <= ~q;
          default: q <= q;
        endcase
      end
    end
  end

endmodule

// File: rtl/jk_reg_bank.sv
// WIDTH-bit JK bank acting as JK bits, up/down counter or load register.
// Optional per-bit change pulses on chg when JKBANK_CHG_EN is defined.
module jk_reg_bank
  import jk_pkg::*;
#(
  parameter int unsigned       WIDTH     = 4,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             En,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] J,
  input  logic [WIDTH-1:0] K,
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic             tc
`ifdef JKBANK_CHG_EN
  ,
  output logic [WIDTH-1:0] chg
`endif
);

  jk_mode_t         mode_e;
  logic [WIDTH-1:0] ones_below;
  logic [WIDTH-1:0] zeros_below;
  logic [WIDTH-1:0] j_eff;
  logic [WIDTH-1:0] k_eff;
  logic             load;

  assign mode_e = jk_mode_t'(mode);
  assign load   = (mode_e == MODE_LOAD);

  // Counting is a toggle chain: bit i toggles (j=k=1) when all lower bits
  // are 1 (up) or all 0 (down).
  always_comb begin
    ones_below     = '0;
    zeros_below    = '0;
    ones_below[0]  = 1'b1;
    zeros_below[0] = 1'b1;
    for (int unsigned i = 1; i < WIDTH; i++) begin
      ones_below[i]  = ones_below[i-1]  &  Q[i-1];
      zeros_below[i] = zeros_below[i-1] & ~Q[i-1];
    end
  end

  always_comb begin
    j_eff = '0;
    k_eff = '0;
    case (mode_e)
      MODE_JK:   begin j_eff = J;           k_eff = K;           end
      MODE_UP:   begin j_eff = ones_below;  k_eff = ones_below;  end
      MODE_DOWN: begin j_eff = zeros_below; k_eff = zeros_below; end
      default:   begin j_eff = '0;          k_eff = '0;          end
    endcase
  end

  for (genvar g = 0; g < WIDTH; g++) begin : g_cell
    jk_cell #(.RESET_BIT(RESET_VAL[g])) u_cell (
      .clk   (clk),
      .rst_n (reset),
      .en    (En),
      .j     (j_eff[g]),
      .k     (k_eff[g]),
      .load  (load),
      .d     (D[g]),
      .q     (Q[g])
    );
  end

  assign tc = reset & En & (((mode_e == MODE_UP)   & (&Q)) |
                            ((mode_e == MODE_DOWN) & ~(|Q)));

`ifdef JKBANK_CHG_EN
  logic [WIDTH-1:0] chg_next;

  // Predict which bits the coming edge flips, so chg lines up with the new Q.
  always_comb begin
    chg_next = '0;
    if (En) begin
      if (load) chg_next = D ^ Q;
      else      chg_next = (j_eff & k_eff) | (j_eff & ~Q) | (k_eff & Q);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) chg <= '0;
    else        chg <= chg_next;
  end
`endif

endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed self-checking bench for jk_reg_bank (WIDTH=4, RESET_VAL=0).
// Exercises chg as well when JKBANK_CHG_EN is defined.
module tb_jk_reg_bank;

  localparam int unsigned W = 4;

  logic         clk;
  logic         reset;
  logic         En;
  logic [1:0]   mode;
  logic [W-1:0] J;
  logic [W-1:0] K;
  logic [W-1:0] D;
  logic [W-1:0] Q;
  logic         tc;
`ifdef JKBANK_CHG_EN
  logic [W-1:0] chg;
`endif

  int checks = 0;
  int errors = 0;

  jk_reg_bank #(.WIDTH(W), .RESET_VAL(4'b0000)) dut (
    .clk   (clk),
    .reset (reset),
    .En    (En),
    .mode  (mode),
    .J     (J),
    .K     (K),
    .D     (D),
    .Q     (Q),
    .tc    (tc)
`ifdef JKBANK_CHG_EN
    ,
    .chg   (chg)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_val(input logic [W-1:0] v);
    En = 1'b1; mode = 2'b11; D = v;
    step();
  endtask

  task automatic test_reset();
    reset = 1'b0; En = 1'b0; mode = 2'b00; J = '0; K = '0; D = '0;
    #2;
    checks++;
    if (Q !== 4'b0000) begin errors++; $display("FAIL reset_q Q=%b exp=%b", Q, 4'b0000); end
    checks++;
    if (tc !== 1'b0) begin errors++; $display("FAIL reset_tc tc=%b exp=0", tc); end
`ifdef JKBANK_CHG_EN
    checks++;
    if (chg !== 4'b0000) begin errors++; $display("FAIL reset_chg chg=%b exp=0000", chg); end
`endif
    step();
    reset = 1'b1;
    load_val(4'b1010);
    checks++;
    if (Q !== 4'b1010) begin errors++; $display("FAIL load_1010 Q=%b exp=1010", Q); end
    // async reset between edges
    En = 1'b1; mode = 2'b10;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if (Q !== 4'b0000) begin errors++; $display("FAIL async_reset_q Q=%b exp=0000", Q); end
    checks++;
    if (tc !== 1'b0) begin errors++; $display("FAIL async_reset_tc tc=%b exp=0", tc); end
    step();
    reset = 1'b1; En = 1'b0;
    step();
    step();
    checks++;
    if (Q !== 4'b0000) begin errors++; $display("FAIL hold_after_reset Q=%b exp=0000", Q); end
  endtask

  task automatic test_jk();
    En = 1'b1; mode = 2'b00; J = 4'b0101; K = 4'b0011; D = 4'bxxxx;
    step();
    checks++;
    if (Q !== 4'b0101) begin errors++; $display("FAIL jk_edge1 Q=%b exp=0101", Q); end
    checks++;
    if (tc !== 1'b0) begin errors++; $display("FAIL jk_tc tc=%b exp=0", tc); end
    step();
    checks++;
    if (Q !== 4'b0100) begin errors++; $display("FAIL jk_edge2 Q=%b exp=0100", Q); end
    J = 4'b1000; K = 4'b0100;
    step();
    checks++;
    if (Q !== 4'b1000) begin errors++; $display("FAIL jk_set_clr Q=%b exp=1000", Q); end
  endtask

  task automatic test_up();
    load_val(4'b1110);
    checks++;
    if (tc !== 1'b0) begin errors++; $display("FAIL load_tc tc=%b exp=0", tc); end
    mode = 2'b01; J = 4'bxxxx; K = 4'bxxxx; D = 4'bxxxx;
    step();
    checks++;
    if (Q !== 4'b1111) begin errors++; $display("FAIL up_to_max Q=%b exp=1111", Q); end
    checks++;
    if (tc !== 1'b1) begin errors++; $display("FAIL up_tc_max tc=%b exp=1", tc); end
    step();
    checks++;
    if (Q !== 4'b0000) begin errors++; $display("FAIL up_wrap Q=%b exp=0000", Q); end
    checks++;
    if (tc !== 1'b0) begin errors++; $display("FAIL up_tc_wrap tc=%b exp=0", tc); end
  endtask

  task automatic test_down();
    load_val(4'b0001);
    mode = 2'b10;
    step();
    checks++;
    if (Q !== 4'b0000) begin errors++; $display("FAIL down_to_zero Q=%b exp=0000", Q); end
    checks++;
    if (tc !== 1'b1) begin errors++; $display("FAIL down_tc_zero tc=%b exp=1", tc); end
    En = 1'b0;
    #1;
    checks++;
    if (tc !== 1'b0) begin errors++; $display("FAIL tc_en_drop tc=%b exp=0", tc); end
    En = 1'b1;
    #1;
    step();
    checks++;
    if (Q !== 4'b1111) begin errors++; $display("FAIL down_wrap Q=%b exp=1111", Q); end
    checks++;
    if (tc !== 1'b0) begin errors++; $display("FAIL down_tc_wrap tc=%b exp=0", tc); end
    step();
    checks++;
    if (Q !== 4'b1110) begin errors++; $display("FAIL down_1110 Q=%b exp=1110", Q); end
    mode = 2'b01;
    #1;
    checks++;
    if (tc !== 1'b0) begin errors++; $display("FAIL up_tc_1110 tc=%b exp=0", tc); end
    mode = 2'b00;
    #1;
    checks++;
    if (tc !== 1'b0) begin errors++; $display("FAIL jk_tc_zero tc=%b exp=0", tc); end
  endtask

  task automatic test_enable_hold();
    load_val(4'b0011);
    mode = 2'b01; En = 1'b0; D = 4'b1111; J = 4'b1111; K = 4'b1111;
    for (int i = 0; i < 3; i++) step();
    checks++;
    if (Q !== 4'b0011) begin errors++; $display("FAIL en_hold Q=%b exp=0011", Q); end
    En = 1'b1;
    step();
    checks++;
    if (Q !== 4'b0100) begin errors++; $display("FAIL up_carry Q=%b exp=0100", Q); end
  endtask

  task automatic test_back_to_back();
    mode = 2'b11; D = 4'b1001;
    step();
    mode = 2'b10;
    step();
    mode = 2'b10;
    step();
    checks++;
    if (Q !== 4'b0111) begin errors++; $display("FAIL b2b_down Q=%b exp=0111", Q); end
    mode = 2'b01;
    step();
    checks++;
    if (Q !== 4'b1000) begin errors++; $display("FAIL b2b_up Q=%b exp=1000", Q); end
  endtask

`ifdef JKBANK_CHG_EN
  task automatic test_chg();
    load_val(4'b0111);
    mode = 2'b01;
    step();
    checks++;
    if (Q !== 4'b1000) begin errors++; $display("FAIL chg_up_q Q=%b exp=1000", Q); end
    checks++;
    if (chg !== 4'b1111) begin errors++; $display("FAIL chg_all chg=%b exp=1111", chg); end
    step();
    checks++;
    if (chg !== 4'b0001) begin errors++; $display("FAIL chg_bit0 chg=%b exp=0001", chg); end
    En = 1'b0;
    step();
    checks++;
    if (chg !== 4'b0000) begin errors++; $display("FAIL chg_hold chg=%b exp=0000", chg); end
    checks++;
    if (Q !== 4'b1001) begin errors++; $display("FAIL chg_hold_q Q=%b exp=1001", Q); end
  endtask
`endif

  initial begin
    test_reset();
    test_jk();
    test_up();
    test_down();
    test_enable_hold();
    test_back_to_back();
`ifdef JKBANK_CHG_EN
    test_chg();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
